// File: rtl/queue_director_pkg.sv
// Shared constants for the queue director: packet metadata layout, flag values and
// the fallback-mode encoding.
package queue_director_pkg;

  localparam int unsigned QUEUE_ID_W = 32;

  typedef logic [7:0] pkt_flags_t;

  localparam pkt_flags_t PKT_NONE = 8'h00;
  localparam pkt_flags_t PKT_PCIE = 8'h01;
  localparam pkt_flags_t PKT_DROP = 8'h02;

  typedef struct packed {
    logic [15:0]           pkt_len;
    logic [31:0]           pkt_hash;
    logic [QUEUE_ID_W-1:0] pkt_queue_id;
    pkt_flags_t            pkt_flags;
    logic [7:0]            pkt_port;
  } metadata_t;

  typedef enum logic [1:0] {
    FbHash       = 2'b00,
    FbRoundRobin = 2'b01,
    FbSingle     = 2'b10,
    FbHashAlt    = 2'b11
  } fb_mode_e;

endpackage

// File: rtl/queue_director_skid_reg.sv
// One-entry skid buffer in front of a registered output stage. in_ready is a flop
// output, so nothing on the input side depends combinationally on out_ready.
module skid_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  T     in_data,
  input  logic in_valid,
  output logic in_ready,
  output T     out_data,
  output logic out_valid,
  input  logic out_ready
);

  T     skid_data;
  logic skid_valid;
  logic accept;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && !skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_valid && !out_ready) begin
      // Output stalled: hold it and park any newly accepted entry.
      if (accept) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (skid_valid) begin
      out_data   <= skid_data;
      out_valid  <= 1'b1;
      skid_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/queue_director.sv
// Steers packet metadata to a queue: matched packets pass through, unmatched ones are
// spread over a fallback queue range or dropped; keeps per-class counters.
module queue_director
  import queue_director_pkg::*;
#(
  parameter int unsigned QUEUE_ID_WIDTH = 32,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  metadata_t                 in_meta_data,
  input  logic                      in_meta_valid,
  output logic                      in_meta_ready,
  output metadata_t                 out_meta_data,
  output logic                      out_meta_valid,
  input  logic                      out_meta_ready,
  input  logic [31:0]               nb_fallback_queues,
  input  logic [QUEUE_ID_WIDTH-1:0] fallback_base_queue,
  input  logic [1:0]                fallback_mode,
  output logic [CNT_WIDTH-1:0]      matched_cnt,
  output logic [CNT_WIDTH-1:0]      fallback_cnt,
  output logic [CNT_WIDTH-1:0]      drop_cnt
);

  logic [31:0]               mask;
  logic [31:0]               rr_ptr;
  logic [31:0]               offset;
  logic [QUEUE_ID_WIDTH-1:0] fb_qid;
  logic                      unmatched;
  logic                      drop;
  logic                      accept;
  fb_mode_e                  mode;
  metadata_t                 cls_meta;

  assign mask   = nb_fallback_queues - 32'd1;
  assign mode   = fb_mode_e'(fallback_mode);
  assign accept = in_meta_valid && in_meta_ready;

  always_comb begin
    unmatched = &in_meta_data.pkt_queue_id;
    drop      = unmatched && (nb_fallback_queues == 32'd0);
    case (mode)
      FbRoundRobin: offset = rr_ptr & mask;  // masked at use so a shrunk range stays valid
      FbSingle:     offset = 32'd0;
      default:      offset = in_meta_data.pkt_hash & mask;
    endcase
    fb_qid   = fallback_base_queue + QUEUE_ID_WIDTH'(offset);
    cls_meta = in_meta_data;
    if (!unmatched) begin
      cls_meta.pkt_flags = PKT_PCIE;
    end else if (drop) begin
      cls_meta.pkt_flags = PKT_DROP;
    end else begin
      cls_meta.pkt_flags    = PKT_PCIE;
      cls_meta.pkt_queue_id = QUEUE_ID_W'(fb_qid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= 32'd0;
      matched_cnt  <= '0;
      fallback_cnt <= '0;
      drop_cnt     <= '0;
    end else if (accept) begin
      if (!unmatched) begin
        matched_cnt <= matched_cnt + CNT_WIDTH'(1);
      end else if (drop) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end else begin
        fallback_cnt <= fallback_cnt + CNT_WIDTH'(1);
        if (mode == FbRoundRobin) begin
          rr_ptr <= (rr_ptr + 32'd1) & mask;
        end
      end
    end
  end

  skid_reg #(
    .T(metadata_t)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (cls_meta),
    .in_valid (in_meta_valid),
    .in_ready (in_meta_ready),
    .out_data (out_meta_data),
    .out_valid(out_meta_valid),
    .out_ready(out_meta_ready)
  );

endmodule

// File: tb/tb_queue_director.sv
// Scoreboard bench for queue_director: expected metadata is queued at acceptance and
// compared when the DUT hands it off.
module tb_queue_director;
  import queue_director_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  metadata_t   in_meta_data = '0;
  logic        in_meta_valid = 1'b0;
  logic        in_meta_ready;
  metadata_t   out_meta_data;
  logic        out_meta_valid;
  logic        out_meta_ready = 1'b1;
  logic [31:0] nb_fallback_queues = 32'd0;
  logic [31:0] fallback_base_queue = 32'd0;
  logic [1:0]  fallback_mode = 2'b00;
  logic [31:0] matched_cnt, fallback_cnt, drop_cnt;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;  // 0 high, 1 toggle, 2 low
  int unsigned m_matched = 0, m_fallback = 0, m_drop = 0, m_rr = 0;
  metadata_t sb[$];
  logic [31:0] out_log[$];
  logic hold_valid = 1'b0;
  metadata_t hold_data;

  queue_director #(
    .QUEUE_ID_WIDTH(32),
    .CNT_WIDTH     (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .in_meta_data       (in_meta_data),
    .in_meta_valid      (in_meta_valid),
    .in_meta_ready      (in_meta_ready),
    .out_meta_data      (out_meta_data),
    .out_meta_valid     (out_meta_valid),
    .out_meta_ready     (out_meta_ready),
    .nb_fallback_queues (nb_fallback_queues),
    .fallback_base_queue(fallback_base_queue),
    .fallback_mode      (fallback_mode),
    .matched_cnt        (matched_cnt),
    .fallback_cnt       (fallback_cnt),
    .drop_cnt           (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 0) out_meta_ready = 1'b1;
      else if (ready_mode == 1) out_meta_ready = ~out_meta_ready;
      else out_meta_ready = 1'b0;
    end
  end

  // Monitor: handshakes and output stability, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && out_meta_valid) begin
        checks++;
        if (out_meta_data !== hold_data) begin
          failures++;
          $display("FAIL stall_stable: got %h, required %h", out_meta_data, hold_data);
        end
      end
      if (out_meta_valid && out_meta_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got %h, required no output", out_meta_data);
        end else begin
          metadata_t e;
          e = sb.pop_front();
          if (out_meta_data !== e) begin
            failures++;
            $display("FAIL scoreboard: got %h, required %h", out_meta_data, e);
          end
        end
        out_log.push_back(out_meta_data.pkt_queue_id);
      end
      hold_valid = out_meta_valid && !out_meta_ready;
      hold_data  = out_meta_data;
    end
  end

  function automatic metadata_t mk(logic [31:0] qid, logic [31:0] hash);
    metadata_t p;
    p.pkt_len      = 16'($urandom);
    p.pkt_hash     = hash;
    p.pkt_queue_id = qid;
    p.pkt_flags    = PKT_NONE;
    p.pkt_port     = 8'($urandom);
    return p;
  endfunction

  task automatic push_expected(input metadata_t p);
    metadata_t e;
    logic [31:0] off;
    e = p;
    if (p.pkt_queue_id != 32'hFFFF_FFFF) begin
      e.pkt_flags = PKT_PCIE;
      m_matched++;
    end else if (nb_fallback_queues == 0) begin
      e.pkt_flags = PKT_DROP;
      m_drop++;
    end else begin
      if (fallback_mode == 2'b01) off = m_rr % nb_fallback_queues;
      else if (fallback_mode == 2'b10) off = 0;
      else off = p.pkt_hash % nb_fallback_queues;
      e.pkt_queue_id = fallback_base_queue + off;
      e.pkt_flags = PKT_PCIE;
      if (fallback_mode == 2'b01) m_rr = (off + 1) % nb_fallback_queues;
      m_fallback++;
    end
    sb.push_back(e);
  endtask

  // Leaves valid asserted so consecutive calls are back-to-back; returns 1 ns past
  // the accepting edge.
  task automatic send(input metadata_t p);
    bit acc;
    int n = 0;
    in_meta_data  = p;
    in_meta_valid = 1'b1;
    do begin
      acc = (in_meta_ready === 1'b1);
      if (acc) push_expected(p);
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_meta_ready=0, required 1 within 100 cycles");
    end
  endtask

  task automatic idle();
    in_meta_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    idle();
    while ((sb.size() != 0 || out_meta_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_meta_valid) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending, required 0", name, sb.size());
    end
    checks++;
    if ({matched_cnt, fallback_cnt, drop_cnt} !== {m_matched, m_fallback, m_drop}) begin
      failures++;
      $display("FAIL %s_counts: got %0d/%0d/%0d, required %0d/%0d/%0d", name, matched_cnt,
               fallback_cnt, drop_cnt, m_matched, m_fallback, m_drop);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_meta_ready !== 1'b1 || out_meta_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: got ready=%b valid=%b, required 1/0", in_meta_ready,
               out_meta_valid);
    end
    checks++;
    if ({matched_cnt, fallback_cnt, drop_cnt} !== 96'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d, required 0/0/0", matched_cnt, fallback_cnt,
               drop_cnt);
    end
  endtask

  task automatic test_matched();
    send(mk(32'd5, 32'h1234));
    idle();
    checks++;
    if (out_meta_valid !== 1'b1 || out_meta_data.pkt_queue_id !== 32'd5 ||
        out_meta_data.pkt_flags !== PKT_PCIE) begin
      failures++;
      $display("FAIL matched_latency: got v=%b q=%0d f=%h, required 1/5/01", out_meta_valid,
               out_meta_data.pkt_queue_id, out_meta_data.pkt_flags);
    end
    drain("matched");
    checks++;
    if (matched_cnt !== 32'd1) begin
      failures++;
      $display("FAIL matched_cnt: got %0d, required 1", matched_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] want[6] = '{16, 17, 18, 19, 16, 17};
    nb_fallback_queues  = 32'd4;
    fallback_base_queue = 32'd16;
    fallback_mode       = 2'b01;
    out_log.delete();
    ready_mode = 1;
    for (int i = 0; i < 6; i++) send(mk(32'hFFFF_FFFF, $urandom));
    drain("rr");
    ready_mode = 0;
    checks++;
    if (out_log.size() != 6) begin
      failures++;
      $display("FAIL rr_count: got %0d, required 6", out_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_log[i] !== want[i]) begin
          failures++;
          $display("FAIL rr_seq[%0d]: got %0d, required %0d", i, out_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_hash();
    logic [31:0] want[3] = '{3, 0, 3};
    nb_fallback_queues  = 32'd8;
    fallback_base_queue = 32'd0;
    for (int m = 0; m < 3; m++) begin
      fallback_mode = (m == 0) ? 2'b00 : (m == 1) ? 2'b10 : 2'b11;
      send(mk(32'hFFFF_FFFF, 32'h2B));
      idle();
      checks++;
      if (out_meta_data.pkt_queue_id !== want[m]) begin
        failures++;
        $display("FAIL hash_mode%0d: got %0d, required %0d", fallback_mode,
                 out_meta_data.pkt_queue_id, want[m]);
      end
      drain("hash");
    end
  endtask

  task automatic test_drop();
    nb_fallback_queues = 32'd0;
    fallback_mode      = 2'b01;
    send(mk(32'hFFFF_FFFF, 32'h7));
    idle();
    checks++;
    if (out_meta_data.pkt_flags !== PKT_DROP || out_meta_data.pkt_queue_id !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL drop_meta: got q=%h f=%h, required ffffffff/02",
               out_meta_data.pkt_queue_id, out_meta_data.pkt_flags);
    end
    drain("drop");
    // Round robin resumes where it left off: six packets earlier leave rr_ptr at 2.
    nb_fallback_queues  = 32'd4;
    fallback_base_queue = 32'd16;
    send(mk(32'hFFFF_FFFF, 32'h0));
    idle();
    checks++;
    if (out_meta_data.pkt_queue_id !== 32'd18) begin
      failures++;
      $display("FAIL drop_rr_kept: got %0d, required 18", out_meta_data.pkt_queue_id);
    end
    drain("drop_rr");
  endtask

  task automatic test_backpressure();
    nb_fallback_queues = 32'd4;
    fallback_mode      = 2'b00;
    ready_mode = 2;
    @(posedge clk);
    #3;
    send(mk(32'd100, 32'h0));
    checks++;
    if (in_meta_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready1: got %b, required 1", in_meta_ready);
    end
    send(mk(32'hFFFF_FFFF, 32'h5));
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_meta_ready !== 1'b0 || out_meta_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_full[%0d]: got ready=%b valid=%b, required 0/1", i, in_meta_ready,
                 out_meta_valid);
      end
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
    send(mk(32'd102, 32'h0));
    drain("bp");
  endtask

  task automatic test_reset_mid();
    ready_mode = 2;
    @(posedge clk);
    #3;
    send(mk(32'd9, 32'h0));
    send(mk(32'd10, 32'h0));
    idle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_meta_valid !== 1'b0 || {matched_cnt, fallback_cnt, drop_cnt} !== 96'd0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b cnt=%0d, required 0/0", out_meta_valid,
               matched_cnt);
    end
    sb.delete();
    m_matched = 0;
    m_fallback = 0;
    m_drop = 0;
    m_rr = 0;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (in_meta_ready !== 1'b1 || out_meta_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_after: got ready=%b valid=%b, required 1/0", in_meta_ready,
               out_meta_valid);
    end
    nb_fallback_queues  = 32'd4;
    fallback_base_queue = 32'd16;
    fallback_mode       = 2'b01;
    send(mk(32'hFFFF_FFFF, 32'h0));
    idle();
    checks++;
    if (out_meta_data.pkt_queue_id !== 32'd16) begin
      failures++;
      $display("FAIL mid_rr_cleared: got %0d, required 16", out_meta_data.pkt_queue_id);
    end
    drain("mid");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_matched();
    test_round_robin();
    test_hash();
    test_drop();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/queue_director.md
QUEUE_DIRECTOR -- requirements
Module: queue_director

Interface
REQ-001 SHALL have parameter QUEUE_ID_WIDTH, default 32, width of metadata_t.pkt_queue_id used for fallback arithmetic.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each statistics counter.
REQ-003 SHALL have ports clk  in  1  sole clock; rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_meta_data  in  metadata_t  packet metadata; in_meta_valid  in  1; in_meta_ready  out  1.
REQ-005 SHALL have ports out_meta_data  out  metadata_t; out_meta_valid  out  1; out_meta_ready  in  1.
REQ-006 SHALL have port nb_fallback_queues  in  32  fallback queue count, power of two or zero.
REQ-007 SHALL have port fallback_base_queue  in  QUEUE_ID_WIDTH  first fallback queue id.
REQ-008 SHALL have port fallback_mode  in  2  00 hash, 01 round robin, 10 single queue, 11 treated as 00.
REQ-009 SHALL have ports matched_cnt, fallback_cnt, drop_cnt  out  CNT_WIDTH each  statistics.

Function
REQ-010 SHALL treat a packet as unmatched iff in_meta_data.pkt_queue_id is all ones; otherwise matched.
REQ-011 SHALL pass matched packets with pkt_queue_id unchanged and pkt_flags = PKT_PCIE.
REQ-012 SHALL, for unmatched packets with nb_fallback_queues == 0, set pkt_flags = PKT_DROP and leave pkt_queue_id unchanged.
REQ-013 SHALL, otherwise for unmatched packets, set pkt_flags = PKT_PCIE and pkt_queue_id = fallback_base_queue + offset, modulo 2^QUEUE_ID_WIDTH.
REQ-014 SHALL compute offset as hash & (nb_fallback_queues-1) in mode 00/11, rr_ptr in mode 01, 0 in mode 10.
REQ-015 SHALL pass all other metadata fields unchanged.
REQ-016 SHALL advance rr_ptr to (rr_ptr+1) & (nb_fallback_queues-1) only when an unmatched, non-dropped packet is accepted in mode 01; no advance on stalls, matched packets or other modes.
REQ-017 SHALL mask rr_ptr with the current mask at use, so a shrink of nb_fallback_queues never yields an out-of-range offset.
REQ-018 SHALL sample all configuration inputs at input acceptance (in_meta_valid && in_meta_ready).
REQ-019 SHALL register the output: one-cycle latency from acceptance to out_meta_valid when not stalled.
REQ-020 SHALL include a one-entry skid buffer; in_meta_ready = !skid_valid, registered, with no combinational path from out_meta_ready.
REQ-021 SHALL, when output is valid and stalled while a new packet is accepted, hold the output stable and capture the new packet in the skid buffer.
REQ-022 SHALL, on output handshake with skid valid, move the skid entry to the output next cycle and clear skid_valid.
REQ-023 SHALL keep out_meta_data stable while out_meta_valid && !out_meta_ready.
REQ-024 SHALL sustain one packet per cycle with out_meta_ready held high.
REQ-025 SHALL preserve packet order.
REQ-026 SHALL increment exactly one of matched_cnt, fallback_cnt, drop_cnt per accepted packet, classification per REQ-010..012; counters wrap at 2^CNT_WIDTH.

Reset
REQ-027 SHALL on rst clear out_meta_valid, skid_valid, rr_ptr and all counters; in_meta_ready reads 1 after reset release.
REQ-028 SHALL discard in-flight and skid packets on reset mid-operation; none emitted afterwards.

Structure
REQ-029 SHALL use metadata_t, PKT_PCIE, PKT_DROP from the shared constants package; the fallback_mode encoding enum SHALL be added there.
REQ-030 SHALL implement buffering as a generic sub-module skid_reg parametrised by data type; classification logic stays in queue_director.

Verification
REQ-031 Matched: pkt_queue_id=5, ready high -> out one cycle later, queue 5, PKT_PCIE, matched_cnt=1.
REQ-032 RR: nb_fallback_queues=4, base=16, mode 01, six unmatched packets, ready toggled every cycle -> queues 16,17,18,19,16,17, no skips or repeats.
REQ-033 Hash: nb=8, base=0, mode 00, hash=0x2B -> queue 3; mode 10 -> queue 0.
REQ-034 Drop: nb=0, unmatched -> PKT_DROP, pkt_queue_id all ones, drop_cnt=1, rr_ptr unchanged.
REQ-035 Backpressure: 3 packets back-to-back, out_meta_ready low 3 cycles -> in_meta_ready low after second accepted, output stable, all three emitted in order after release.
REQ-036 Reset mid-stream with output and skid valid -> out_meta_valid 0 immediately, counters 0, no stale packet afterwards.
